// File: rtl/system_top_with_cpu.sv
// Mesh of nodes, each with a fetch-only CPU, threshold-and-fire neurons and a one-hop spike router.
// Latency: spike 1 cycle after the fire write, source router valid +1, destination valid/interrupt +2.
// Backpressure: none; both router ready buses are tied high, so no pulse ever stalls.
module system_top_with_cpu #(
  parameter int          MESH_SIZE_X          = 2,
  parameter int          MESH_SIZE_Y          = 2,
  parameter int          NUM_NEURONS_PER_BANK = 4,
  parameter int          PROG_DEPTH           = 64,
  parameter logic [31:0] DEFAULT_THRESHOLD    = 32'h42480000,
  localparam int         NUM_NODES            = MESH_SIZE_X * MESH_SIZE_Y
) (
  input  logic                                      clk,
  input  logic                                      rst_n,  // active-high synchronous reset despite the name
  input  logic [NUM_NODES-1:0]                      prog_load_enable,
  input  logic [31:0]                               prog_load_addr,
  input  logic [31:0]                               prog_load_data,
  input  logic [NUM_NODES-1:0]                      prog_load_write,
  input  logic [7:0]                                ext_node_select,
  input  logic [7:0]                                ext_neuron_id,
  input  logic [31:0]                               ext_input_current,
  input  logic                                      ext_input_valid,
  output logic [NUM_NODES-1:0]                      cpu_interrupt,
  output logic [NUM_NODES*NUM_NEURONS_PER_BANK-1:0] spike_out,
  output logic [NUM_NODES*5-1:0]                    router_input_valid,
  output logic [NUM_NODES*5-1:0]                    router_input_ready,
  output logic [NUM_NODES*5-1:0]                    router_output_valid,
  output logic [NUM_NODES*5-1:0]                    router_output_ready
);

  localparam int NB  = NUM_NODES * NUM_NEURONS_PER_BANK;
  localparam int KW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW  = $clog2(PROG_DEPTH);   // PROG_DEPTH is a power of two so the PC wraps naturally
  localparam int PCW = AW + 2;

  // Router port a node sends on: East towards x+1, West from the last column, Local for a 1-wide mesh.
  function automatic int dir_of(input int n);
    if (MESH_SIZE_X == 1) return 0;
    else if ((n % MESH_SIZE_X) < MESH_SIZE_X - 1) return 2;
    else return 4;
  endfunction

  function automatic int partner_of(input int n);
    if (MESH_SIZE_X == 1) return n;
    else if ((n % MESH_SIZE_X) < MESH_SIZE_X - 1) return n + 1;
    else return n - 1;
  endfunction

  // Port the packet arrives on at the partner: the mirror of the sending port.
  function automatic int arrive_of(input int n);
    if (dir_of(n) == 2) return 4;
    else if (dir_of(n) == 4) return 2;
    else return 0;
  endfunction

  logic [31:0]   cur_q [NB];
  logic [31:0]   thr_q [NB];
  logic [NB-1:0] spike_q, spike_d;
  logic [NUM_NODES*5-1:0] out_vld_q, out_vld_d;
  logic [NUM_NODES*5-1:0] in_vld_q, in_vld_d;

  logic [3:0]    sel_x, sel_y;
  logic [4:0]    sel_nid;
  logic [2:0]    sel_off;
  logic          wr_hit;
  logic          fire;
  logic [KW-1:0] wr_k;

  // Decode the external write and evaluate the fire condition against the addressed neuron.
  always_comb begin
    sel_x   = ext_node_select[3:0];
    sel_y   = ext_node_select[7:4];
    sel_nid = ext_neuron_id[7:3];
    sel_off = ext_neuron_id[2:0];
    wr_hit  = ext_input_valid && (int'(sel_x) < MESH_SIZE_X) && (int'(sel_y) < MESH_SIZE_Y)
              && (int'(sel_nid) < NUM_NEURONS_PER_BANK);
    wr_k    = '0;
    fire    = 1'b0;
    spike_d = '0;
    if (wr_hit) begin
      wr_k = KW'((int'(sel_y) * MESH_SIZE_X + int'(sel_x)) * NUM_NEURONS_PER_BANK + int'(sel_nid));
      // Magnitude compare on the raw bits orders positive floats correctly.
      fire = (sel_off == 3'd6) && ext_input_current[0] && !cur_q[wr_k][31]
             && (cur_q[wr_k][30:0] >= thr_q[wr_k][30:0]);
      spike_d[wr_k] = fire;
    end
  end

  // Neuron register file and one-cycle spike pulse; a spike clears its current register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NB; k++) begin
        cur_q[k] <= '0;
        thr_q[k] <= DEFAULT_THRESHOLD;
      end
      spike_q <= '0;
    end else begin
      spike_q <= spike_d;
      if (wr_hit) begin
        case (sel_off)
          3'd0:    cur_q[wr_k] <= ext_input_current;
          3'd1:    thr_q[wr_k] <= ext_input_current;
          3'd6:    if (fire) cur_q[wr_k] <= '0;
          default: ;
        endcase
      end
    end
  end

  // Two-stage hop: source output valid follows a spike, destination input valid follows that.
  always_comb begin
    out_vld_d = '0;
    in_vld_d  = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      if (|spike_q[n*NUM_NEURONS_PER_BANK +: NUM_NEURONS_PER_BANK]) out_vld_d[n*5 + dir_of(n)] = 1'b1;
      if (out_vld_q[n*5 + dir_of(n)]) in_vld_d[partner_of(n)*5 + arrive_of(n)] = 1'b1;
    end
  end

  // Router pulse pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_vld_q <= '0;
      in_vld_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      in_vld_q  <= in_vld_d;
    end
  end

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    logic [31:0]    mem_q [PROG_DEPTH];
    logic [PCW-1:0] pc_q, pc_d;
    logic [31:0]    instr;
    logic [20:0]    j_imm;
    logic [31:0]    widx;
    logic           unused_cpu;

    assign widx = {26'd0, prog_load_addr[7:2]};

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
      if (prog_load_enable[n] && prog_load_write[n] && (widx < 32'(PROG_DEPTH)))
        mem_q[widx[AW-1:0]] <= prog_load_data;
    end

    assign instr = mem_q[pc_q[PCW-1:2]];

    // Next PC: JAL adds its J-immediate (truncation gives the modulo wrap), everything else steps by 4.
    always_comb begin
      j_imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      pc_d  = pc_q + PCW'(4);
      if (instr[6:0] == 7'h6F) pc_d = pc_q + j_imm[PCW-1:0];
    end

    // PC register, parked at 0 while this node is in load mode.
    always_ff @(posedge clk) begin
      if (rst_n || prog_load_enable[n]) pc_q <= '0;
      else                              pc_q <= pc_d;
    end

    assign unused_cpu       = ^{instr[11:7], j_imm[20:PCW]};
    assign cpu_interrupt[n] = |in_vld_q[n*5 +: 5];
  end

  logic unused_top;
  assign unused_top = ^{prog_load_addr[31:8], prog_load_addr[1:0]};

  assign spike_out           = spike_q;
  assign router_output_valid = out_vld_q;
  assign router_input_valid  = in_vld_q;
  assign router_input_ready  = '1;
  assign router_output_ready = '1;

endmodule

// File: tb/tb_system_top_with_cpu.sv
// Directed bench for the neuromorphic mesh top with a scheduled-pulse reference model.
// Latency: checks every cycle on the falling edge against pulses booked when each write is issued.
// Backpressure: none exercised; ready buses are checked to stay all ones.
module tb_system_top_with_cpu;
  localparam int MX = 2, MY = 2, NN = 4, NODES = 4, NB = 16, DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  prog_load_enable, prog_load_write;
  logic [31:0] prog_load_addr, prog_load_data;
  logic [7:0]  ext_node_select, ext_neuron_id;
  logic [31:0] ext_input_current;
  logic        ext_input_valid;
  logic [3:0]  cpu_interrupt;
  logic [15:0] spike_out;
  logic [19:0] router_input_valid, router_input_ready, router_output_valid, router_output_ready;

  always #5 clk = ~clk;

  system_top_with_cpu dut (
    .clk(clk), .rst_n(rst_n),
    .prog_load_enable(prog_load_enable), .prog_load_addr(prog_load_addr),
    .prog_load_data(prog_load_data), .prog_load_write(prog_load_write),
    .ext_node_select(ext_node_select), .ext_neuron_id(ext_neuron_id),
    .ext_input_current(ext_input_current), .ext_input_valid(ext_input_valid),
    .cpu_interrupt(cpu_interrupt), .spike_out(spike_out),
    .router_input_valid(router_input_valid), .router_input_ready(router_input_ready),
    .router_output_valid(router_output_valid), .router_output_ready(router_output_ready)
  );

  int n_cmp = 0, n_bad = 0;
  int ecnt = 0;
  bit chk_en = 0, count_en = 0;
  int irq1_cnt = 0, spike_pulses = 0;
  logic [15:0] spike_acc = '0;

  // Reference: expected output value for the cycle following edge number e.
  logic [15:0] exp_spike [DEPTH];
  logic [19:0] exp_out   [DEPTH];
  logic [19:0] exp_in    [DEPTH];
  logic [3:0]  exp_irq   [DEPTH];
  logic [31:0] m_cur [NB];
  logic [31:0] m_thr [NB];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", nm, act, req, ecnt);
    end
  endtask

  // Apply the effect of the upcoming edge e to the model and book any resulting pulses.
  task automatic model_edge(input int e, input logic r, input logic [7:0] sel, input logic [7:0] id,
                            input logic [31:0] d, input logic v);
    int x, y, nid, off, node, k, dst, op, ip;
    if (r) begin
      for (int i = e; i < e + 4; i++) begin
        exp_spike[i] = '0; exp_out[i] = '0; exp_in[i] = '0; exp_irq[i] = '0;
      end
      for (int j = 0; j < NB; j++) begin m_cur[j] = '0; m_thr[j] = 32'h42480000; end
    end else if (v) begin
      x = int'(sel[3:0]); y = int'(sel[7:4]); nid = int'(id[7:3]); off = int'(id[2:0]);
      if (x < MX && y < MY && nid < NN) begin
        node = y * MX + x;
        k = node * NN + nid;
        if (off == 0) m_cur[k] = d;
        else if (off == 1) m_thr[k] = d;
        else if (off == 6 && d[0] && !m_cur[k][31] && m_cur[k][30:0] >= m_thr[k][30:0]) begin
          m_cur[k] = '0;
          if (x < MX - 1) begin dst = node + 1; op = 2; ip = 4; end
          else begin dst = node - 1; op = 4; ip = 2; end
          exp_spike[e][k] = 1'b1;
          exp_out[e+1][node*5+op] = 1'b1;
          exp_in[e+2][dst*5+ip] = 1'b1;
          exp_irq[e+2][dst] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] le, input logic [3:0] lw,
                       input logic [31:0] la, input logic [31:0] ld,
                       input logic [7:0] sel, input logic [7:0] id, input logic [31:0] d, input logic v);
    @(negedge clk);
    rst_n = r; prog_load_enable = le; prog_load_write = lw; prog_load_addr = la; prog_load_data = ld;
    ext_node_select = sel; ext_neuron_id = id; ext_input_current = d; ext_input_valid = v;
    model_edge(ecnt + 1, r, sel, id, d, v);
  endtask

  task automatic ext(input logic [7:0] sel, input logic [7:0] id, input logic [31:0] d);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, sel, id, d, 1'b1);
  endtask
  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 8'h0, 8'h0, 32'h0, 1'b0);
  endtask
  task automatic rst_cyc();
    drive(1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 8'h0, 8'h0, 32'h0, 1'b0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("spike_out", 64'(spike_out), 64'(exp_spike[ecnt]));
      chk("router_output_valid", 64'(router_output_valid), 64'(exp_out[ecnt]));
      chk("router_input_valid", 64'(router_input_valid), 64'(exp_in[ecnt]));
      chk("cpu_interrupt", 64'(cpu_interrupt), 64'(exp_irq[ecnt]));
      chk("router_input_ready", 64'(router_input_ready), 64'h0FFFFF);
      chk("router_output_ready", 64'(router_output_ready), 64'h0FFFFF);
    end
  end

  always @(negedge clk) begin
    if (count_en) begin
      irq1_cnt     += int'(cpu_interrupt[1]);
      spike_pulses += $countones(spike_out);
      spike_acc    |= spike_out;
    end
  end

  logic [31:0] prog [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_spike[i] = '0; exp_out[i] = '0; exp_in[i] = '0; exp_irq[i] = '0;
    end
    for (int j = 0; j < NB; j++) begin m_cur[j] = '0; m_thr[j] = 32'h42480000; end
    rst_n = 1'b1; prog_load_enable = '0; prog_load_write = '0; prog_load_addr = '0; prog_load_data = '0;
    ext_node_select = '0; ext_neuron_id = '0; ext_input_current = '0; ext_input_valid = 1'b0;

    rst_cyc(); rst_cyc(); idle();
    chk_en = 1'b1;
    chk("reset spike_out", 64'(spike_out), 64'h0);
    chk("reset router_output_valid", 64'(router_output_valid), 64'h0);
    chk("reset router_input_valid", 64'(router_input_valid), 64'h0);
    chk("reset cpu_interrupt", 64'(cpu_interrupt), 64'h0);
    chk("reset ready", 64'(router_input_ready & router_output_ready), 64'h0FFFFF);

    // Program load: three NOPs then a spin-in-place JAL on every node; a neuron write during load mode.
    prog[0] = 32'h00000013; prog[1] = 32'h00000013; prog[2] = 32'h00000013; prog[3] = 32'h0000006F;
    for (int i = 0; i < 4; i++) drive(1'b0, 4'hF, 4'hF, 32'(i * 4), prog[i], 8'h0, 8'h0, 32'h0, 1'b0);
    drive(1'b0, 4'hF, 4'h0, 32'h0, 32'h0, 8'h00, 8'h00, 32'h00000000, 1'b1);
    repeat (10) idle();

    // Node (0,0) fires towards (1,0).
    ext(8'h00, 8'h00, 32'h42C80000); ext(8'h00, 8'h06, 32'h1);
    idle(); chk("n0 spike", 64'(spike_out), 64'h0001);
    idle(); chk("n0 out_vld", 64'(router_output_valid), 64'h00004);
    idle(); chk("n0 in_vld", 64'(router_input_valid), 64'h00200);
    chk("n0 irq", 64'(cpu_interrupt), 64'h2);

    // Node (1,0): threshold 100.0, zero current must not fire; then 100.0 current fires West.
    ext(8'h01, 8'h01, 32'h42C80000); ext(8'h01, 8'h06, 32'h1);
    idle(); chk("n1 nofire spike", 64'(spike_out), 64'h0);
    idle(); chk("n1 nofire out", 64'(router_output_valid), 64'h0);
    idle(); chk("n1 nofire irq", 64'(cpu_interrupt), 64'h0);
    ext(8'h01, 8'h00, 32'h42C80000); ext(8'h01, 8'h06, 32'h1);
    idle(); chk("n1 spike", 64'(spike_out), 64'h0010);
    idle(); chk("n1 out_vld", 64'(router_output_valid), 64'h00200);
    idle(); chk("n1 in_vld", 64'(router_input_valid), 64'h00004);
    chk("n1 irq", 64'(cpu_interrupt), 64'h1);

    // Back-to-back fires of all four node-0 neurons stay separate pulses.
    for (int i = 0; i < 4; i++) ext(8'h00, 8'(i << 3), 32'h43960000);
    count_en = 1'b1;
    for (int i = 0; i < 4; i++) ext(8'h00, 8'((i << 3) | 6), 32'h1);
    repeat (6) idle();
    count_en = 1'b0;
    chk("burst irq1 pulses", 64'(irq1_cnt), 64'd4);
    chk("burst spike pulses", 64'(spike_pulses), 64'd4);
    chk("burst spike bits", 64'(spike_acc), 64'h000F);

    // Equal-to-threshold fires on node (1,1) neuron 2, routed West to (0,1).
    ext(8'h11, 8'h10, 32'h42480000); ext(8'h11, 8'h16, 32'h1);
    idle(); chk("eq spike", 64'(spike_out), 64'h4000);
    idle(); chk("eq out_vld", 64'(router_output_valid), 64'h80000);
    idle(); chk("eq in_vld", 64'(router_input_valid), 64'h01000);
    chk("eq irq", 64'(cpu_interrupt), 64'h4);

    // Just below threshold, negative current, out-of-range targets, ignored offsets and data[0]=0.
    ext(8'h11, 8'h10, 32'h4247FFFF); ext(8'h11, 8'h16, 32'h1);
    idle(); chk("below spike", 64'(spike_out), 64'h0);
    ext(8'h00, 8'h00, 32'hC2C80000); ext(8'h00, 8'h06, 32'h1);
    idle(); chk("neg spike", 64'(spike_out), 64'h0);
    ext(8'h22, 8'h00, 32'h43960000); ext(8'h22, 8'h06, 32'h1);
    idle(); chk("sel22 spike", 64'(spike_out), 64'h0);
    ext(8'h02, 8'h00, 32'h43960000); ext(8'h02, 8'h06, 32'h1);
    idle(); chk("sel02 spike", 64'(spike_out), 64'h0);
    ext(8'h00, 8'h20, 32'h43960000); ext(8'h00, 8'h26, 32'h1);
    idle(); chk("nid4 spike", 64'(spike_out), 64'h0);
    ext(8'h00, 8'h06, 32'h1);
    idle(); chk("nid4 no alias", 64'(spike_out), 64'h0);
    ext(8'h10, 8'h02, 32'h43960000); ext(8'h10, 8'h06, 32'h1);
    idle(); chk("off2 ignored", 64'(spike_out), 64'h0);
    ext(8'h00, 8'h08, 32'h43960000); ext(8'h00, 8'h0E, 32'h2);
    idle(); chk("data0 clear", 64'(spike_out), 64'h0);
    ext(8'h00, 8'h0E, 32'h1);
    idle(); chk("data0 set", 64'(spike_out), 64'h0002);
    repeat (3) idle();

    // Reset right after a fire drops the in-flight router pulses.
    ext(8'h10, 8'h00, 32'h43960000); ext(8'h10, 8'h06, 32'h1);
    idle(); chk("pre-reset spike", 64'(spike_out), 64'h0100);
    rst_cyc();
    idle(); chk("reset drops out_vld", 64'(router_output_valid), 64'h0);
    idle(); chk("reset drops in_vld", 64'(router_input_valid), 64'h0);
    chk("reset drops irq", 64'(cpu_interrupt), 64'h0);

    // Thresholds and currents return to defaults after reset.
    ext(8'h01, 8'h00, 32'h42480000); ext(8'h01, 8'h06, 32'h1);
    idle(); chk("thr default after reset", 64'(spike_out), 64'h0010);
    ext(8'h10, 8'h06, 32'h1);
    idle(); chk("cur cleared by reset", 64'(spike_out), 64'h0);
    repeat (4) idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/system_top_with_cpu.md
Name: system_top_with_cpu

Overview:
- Minimal neuromorphic system top: a MESH_SIZE_X x MESH_SIZE_Y mesh of nodes.
- Each node has a tiny instruction-fetch CPU with loadable program memory, a bank of threshold-and-fire neurons, and a one-hop spike router.
- External ports load programs, write neuron registers and fire neurons; spikes, router handshakes and CPU interrupts are exported for observation.

Parameters:
- MESH_SIZE_X, 2, mesh columns.
- MESH_SIZE_Y, 2, mesh rows.
- NUM_NEURONS_PER_BANK, 4, neurons per node (max 32).
- PROG_DEPTH, 64, program memory words per node.
- DEFAULT_THRESHOLD, 32'h42480000, reset threshold of every neuron (50.0 as IEEE-754 single).
- NUM_NODES, MESH_SIZE_X*MESH_SIZE_Y, derived; node n = y*MESH_SIZE_X + x.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted when 1, sampled on rising clk edge).
- prog_load_enable  in  NUM_NODES  per-node load mode; stalls that node's CPU.
- prog_load_addr  in  32  byte address; word index = addr[7:2].
- prog_load_data  in  32  instruction word.
- prog_load_write  in  NUM_NODES  per-node write strobe.
- ext_node_select  in  8  {y[3:0], x[3:0]} of the target node.
- ext_neuron_id  in  8  register address: [7:3] neuron index, [2:0] register offset.
- ext_input_current  in  32  write data.
- ext_input_valid  in  1  write strobe.
- cpu_interrupt  out  NUM_NODES  spike-packet-arrival pulse per node.
- spike_out  out  NUM_NODES*NUM_NEURONS_PER_BANK  bit node*NUM_NEURONS_PER_BANK+neuron.
- router_input_valid, router_input_ready, router_output_valid, router_output_ready  out  NUM_NODES*5 each
  - slice [n*5 +: 5] belongs to node n.
  - port index: 0 Local, 1 North, 2 East, 3 South, 4 West.

Behaviour:
- Reset (rst_n=1): every output 0 except both ready buses, which are all 1. Each CPU PC=0. Neuron current regs=0. Thresholds=DEFAULT_THRESHOLD. Program memory is not cleared.
- Program load:
  - On a clock edge with prog_load_enable[n] and prog_load_write[n] both 1: mem_n[addr[7:2]] <= data.
  - Word indices >= PROG_DEPTH are ignored.
  - While prog_load_enable[n]=1: PC_n is held at 0 and no fetch occurs.
- CPU, one instruction per cycle when not in load mode:
  - Opcode 7'h6F (JAL): PC <= PC + sign-extended J-immediate. Offset 0 means spin in place.
  - Every other word, including 0x00000013: PC <= PC+4.
  - PC wraps modulo PROG_DEPTH*4.
  - The CPU has no other architectural side effects.
- External write, accepted on an edge where ext_input_valid=1:
  - Target must have x<MESH_SIZE_X, y<MESH_SIZE_Y and neuron index<NUM_NEURONS_PER_BANK; otherwise the write is ignored.
  - Offset 0: current register <= data.
  - Offset 1: threshold <= data.
  - Offset 6 with data[0]=1: fire evaluation.
  - All other offsets are ignored.
- Fire evaluation:
  - Spike if current[31]==0 and current[30:0] >= threshold[30:0] (unsigned compare, valid for positive floats).
  - On spike: spike_out bit is 1 for exactly the cycle after the accepted edge (E0->E1). Current register is cleared to 0 on the same edge.
  - No spike: registers unchanged, no output activity.
- Spike routing:
  - Partner of node (x,y): (x+1,y) if x<MESH_SIZE_X-1, else (x-1,y). With MESH_SIZE_X=1, the node delivers to itself via Local (port 0).
  - Source: router_output_valid[src*5+dir] pulses for one cycle at E1->E2. dir = East(2) or West(4).
  - Destination: router_input_valid[dst*5+opposite dir] and cpu_interrupt[dst] pulse together for one cycle at E2->E3.
  - Ready is always 1, so nothing stalls.
- Simultaneous events:
  - Only one fire per cycle is possible per system, so at most one packet is in flight per node per cycle.
  - Pulses from back-to-back fires are pipelined, not merged.
- Reset mid-operation clears all in-flight pulses within the same edge.

Test Plan:
- Reset then release: all outputs 0 except ready buses, which are all 1s (20'hFFFFF for the 2x2 mesh); thresholds read back behaviourally as 50.0 (100.0 fires).
- Load NOP,NOP,NOP,0x0000006F at words 0..3 on all nodes -> after load, PC sequence 0,4,8,C,C,C...; a write during load_enable keeps PC at 0.
- Node(0,0) write addr 0x00 with 0x42C80000, then addr 0x06 with data 1 -> spike_out[0] pulses 1 cycle, router_output_valid[2] next cycle, then router_input_valid[1*5+4] and cpu_interrupt[1] one cycle later.
- Node(1,0) write addr 0x01 with 0x42C80000 (threshold 100.0), fire neuron 0 with current 0 -> no spike, no router activity. Then write current 0x42C80000 and fire -> spike_out[4] pulses, router_output_valid[1*5+4] pulses, cpu_interrupt[0] pulses.
- Node(0,0) neurons 0..3 each written 0x43960000 (300.0) and fired in sequence -> spike_out[0..3] each pulse once; four cpu_interrupt[1] pulses.
- Negative current 0xC2C80000, an out-of-range node select 0x22, and neuron index 4 -> no spike, no state change.
